// File: rtl/linebuffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : linebuffer_pkg                                               |
// | Description : Shared width helpers for the RAM-based line buffer.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package linebuffer_pkg;

   // Width type for the RAM column pointer and the fill counter.
   typedef int unsigned width_t;

   // Bits needed to address DEPTH columns (at least one bit).
   function automatic width_t ptr_width(input width_t depth);
      return (depth > 1) ? width_t'($clog2(depth)) : width_t'(1);
   endfunction

   // Bits needed to count up to (taps-1)*depth accepted samples.
   function automatic width_t fill_width(input width_t depth, input width_t taps);
      return width_t'($clog2((taps - 1) * depth + 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter                                                      |
// | Description : Enabled up-counter that wraps to zero after max_i, with a    |
// |               synchronous clear and asynchronous active-low reset.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module counter #(
   parameter int WIDTH_P = 4
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [WIDTH_P-1:0] max_i,
   output logic [WIDTH_P-1:0] cnt_o
);

   logic [WIDTH_P-1:0] cnt_q;
   logic [WIDTH_P-1:0] cnt_d;

   // Next count: clear wins, otherwise step and wrap at max_i.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == max_i) ? '0 : cnt_q + WIDTH_P'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sync_ram_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_ram_block                                               |
// | Description : Simple dual-port RAM, one write and one registered read.     |
// |               The read register holds its value when re_i is low.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_ram_block import linebuffer_pkg::*; #(
   parameter int WIDTH_P = 8,
   parameter int DEPTH_P = 16,
   parameter int AW_P    = int'(ptr_width(DEPTH_P))
) (
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [AW_P-1:0]    waddr_i,
   input  logic [WIDTH_P-1:0] wdata_i,
   input  logic               re_i,
   input  logic [AW_P-1:0]    raddr_i,
   output logic [WIDTH_P-1:0] rdata_o
);

   logic [WIDTH_P-1:0] mem_q [DEPTH_P];
   logic [WIDTH_P-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; output held between reads.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ramlinebuffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ramlinebuffer                                                |
// | Description : Streaming line buffer producing TAPS_P vertically aligned    |
// |               samples per column from one RAM holding TAPS_P-1 lines.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ramlinebuffer import linebuffer_pkg::*; #(
   parameter int WIDTH_P = 8,
   parameter int DEPTH_P = 640,
   parameter int TAPS_P  = 3
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         clear_i,
   input  logic [$clog2(DEPTH_P+1)-1:0] len_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [WIDTH_P-1:0]           data_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [TAPS_P*WIDTH_P-1:0]    data_o
);

   localparam int LW = $clog2(DEPTH_P + 1);
   localparam int AW = int'(ptr_width(DEPTH_P));
   localparam int FW = int'(fill_width(DEPTH_P, TAPS_P));
   localparam int RW = (TAPS_P - 1) * WIDTH_P;

   logic [LW-1:0]      len_q;
   logic [LW-1:0]      len_eff;
   logic               run_q;
   logic               s1_valid_q, s1_valid_d;
   logic               primed_q, primed_d;
   logic [WIDTH_P-1:0] s1_data_q;
   logic [AW-1:0]      s1_col_q;
   logic [AW-1:0]      col;
   logic [AW-1:0]      col_max;
   logic [FW-1:0]      fill;
   logic [FW-1:0]      fill_target;
   logic [RW-1:0]      ram_q;
   logic [RW-1:0]      wr_word;
   logic               advance;
   logic               beat;

   // Line length is only taken from len_i right after reset or on a clear.
   assign len_eff     = (!run_q || clear_i) ? len_i : len_q;
   assign col_max     = AW'(len_eff - LW'(1));
   assign fill_target = FW'(TAPS_P - 1) * FW'(len_eff);

   // Pre-primed samples drain regardless of ready_i; they only feed the RAM.
   assign advance = s1_valid_q & (ready_i | ~primed_q);
   assign ready_o = run_q & ~clear_i & (~s1_valid_q | advance);
   assign beat    = valid_i & ready_o;
   assign valid_o = s1_valid_q & primed_q;
   assign data_o  = {ram_q, s1_data_q};

   // Stored lines shift by one slot: newest line enters slice 0.
   generate
      if (TAPS_P == 2) begin : g_wr_single
         assign wr_word = s1_data_q;
      end else begin : g_wr_shift
         assign wr_word = {ram_q[(TAPS_P-2)*WIDTH_P-1:0], s1_data_q};
      end
   endgenerate

   // Next S1 occupancy and primed flag; clear overrides any beat.
   always_comb begin
      s1_valid_d = s1_valid_q;
      primed_d   = primed_q;
      if (clear_i) begin
         s1_valid_d = 1'b0;
         primed_d   = 1'b0;
      end else begin
         if (beat) begin
            s1_valid_d = 1'b1;
         end else if (advance) begin
            s1_valid_d = 1'b0;
         end
         // The beat arriving after (TAPS_P-1) full lines is the first real column.
         if (beat && (fill == fill_target)) begin
            primed_d = 1'b1;
         end
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_valid_q <= 1'b0;
         primed_q   <= 1'b0;
         run_q      <= 1'b0;
         len_q      <= LW'(DEPTH_P);
      end else begin
         s1_valid_q <= s1_valid_d;
         primed_q   <= primed_d;
         run_q      <= 1'b1;
         len_q      <= len_eff;
      end
   end

   // S1 payload captured on every accepted beat.
   always_ff @(posedge clk_i) begin
      if (beat) begin
         s1_data_q <= data_i;
         s1_col_q  <= col;
      end
   end

   counter #(.WIDTH_P(AW)) u_col_cnt (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (clear_i),
      .en_i   (beat),
      .max_i  (col_max),
      .cnt_o  (col)
   );

   counter #(.WIDTH_P(FW)) u_fill_cnt (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (clear_i),
      .en_i   (beat & (fill != fill_target)),
      .max_i  (fill_target),
      .cnt_o  (fill)
   );

   sync_ram_block #(.WIDTH_P(RW), .DEPTH_P(DEPTH_P), .AW_P(AW)) u_ram (
      .clk_i   (clk_i),
      .we_i    (advance),
      .waddr_i (s1_col_q),
      .wdata_i (wr_word),
      .re_i    (beat),
      .raddr_i (col),
      .rdata_o (ram_q)
   );

endmodule
`default_nettype wire

// File: tb/tb_ramlinebuffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ramlinebuffer                                             |
// | Description : Scoreboard bench for ramlinebuffer with a line-history model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ramlinebuffer;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int T  = 3;
   localparam int LW = $clog2(D + 1);

   logic             clk_i = 1'b0;
   logic             rstn_i;
   logic             clear_i;
   logic [LW-1:0]    len_i;
   logic             valid_i;
   logic             ready_o;
   logic [W-1:0]     data_i;
   logic             valid_o;
   logic             ready_i;
   logic [T*W-1:0]   data_o;

   int               checks = 0;
   int               errors = 0;
   logic [T*W-1:0]   sb[$];
   logic [W-1:0]     hist[$];
   int               mlen = 4;

   always #5 clk_i = ~clk_i;

   ramlinebuffer #(.WIDTH_P(W), .DEPTH_P(D), .TAPS_P(T)) dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clear_i (clear_i),
      .len_i   (len_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o)
   );

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: column for beat n is {hist[n-2L], hist[n-L], hist[n]} once n >= (T-1)*L.
   task automatic model_beat(input logic [W-1:0] d);
      int n;
      logic [T*W-1:0] colv;
      n = hist.size();
      hist.push_back(d);
      if (n >= (T - 1) * mlen) begin
         for (int k = 0; k < T; k++) colv[k*W +: W] = hist[n - k*mlen];
         sb.push_back(colv);
      end
   endtask

   task automatic model_reset(input int len);
      hist.delete();
      sb.delete();
      mlen = len;
   endtask

   // One clock of stimulus; entered and left at posedge+1.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                        input logic clr, input int nlen, output bit beat);
      valid_i = v; data_i = d; ready_i = r; clear_i = clr; len_i = LW'(nlen);
      @(negedge clk_i);
      beat = 1'b0;
      if (clr) begin
         check(ready_o == 1'b0, "ready_during_clear", 32'(ready_o), 0);
      end else if (v && ready_o) begin
         beat = 1'b1;
         model_beat(d);
      end
      @(posedge clk_i);
      #1;
      if (clr) model_reset(nlen);
   endtask

   task automatic send(input logic [W-1:0] d);
      bit b;
      int tries;
      tries = 0;
      do begin
         cycle(1'b1, d, 1'b1, 1'b0, mlen, b);
         tries++;
      end while (!b && tries < 20);
      check(b, "send_accept", 32'(b), 1);
   endtask

   task automatic drain();
      bit b;
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         cycle(1'b0, '0, 1'b1, 1'b0, mlen, b);
         n++;
      end
      check(sb.size() == 0, "drain", 32'(sb.size()), 0);
   endtask

   task automatic do_reset(input int len);
      valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0;
      rstn_i  = 1'b0;
      model_reset(len);
      #1;
      check(valid_o == 1'b0, "valid_in_reset", 32'(valid_o), 0);
      check(ready_o == 1'b0, "ready_in_reset", 32'(ready_o), 0);
      repeat (2) @(posedge clk_i);
      #1;
      len_i  = LW'(len);
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;
      check(ready_o == 1'b1, "ready_after_release", 32'(ready_o), 1);
   endtask

   // Pops the scoreboard on each output transfer and checks hold stability.
   task automatic monitor();
      logic           hold;
      logic           flush;
      logic [T*W-1:0] held;
      logic [T*W-1:0] exp;
      hold = 1'b0; flush = 1'b0; held = '0;
      forever begin
         @(negedge clk_i);
         if (hold && !flush && rstn_i)
            check(valid_o && (data_o == held), "stable_hold", 32'(data_o), 32'(held));
         if (rstn_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_output", 32'(data_o), 0);
            end else begin
               exp = sb.pop_front();
               check(data_o === exp, "column", 32'(data_o), 32'(exp));
            end
         end
         hold  = rstn_i && valid_o && !ready_i;
         held  = data_o;
         flush = clear_i;
      end
   endtask

   initial begin
      bit             b;
      int             beats;
      int             cyc;
      logic [T*W-1:0] stall_col;
      rstn_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      data_i = '0; len_i = LW'(4);
      fork
         monitor();
         begin
            #2_000_000;
            $display("FAIL watchdog: simulation did not finish in time");
            $fatal(1, "watchdog");
         end
      join_none
      @(posedge clk_i);
      #1;
      do_reset(4);

      // Stream 0..15 with a 5-cycle downstream stall while column {2,6,10} is shown.
      stall_col = {8'd2, 8'd6, 8'd10};
      for (int i = 0; i < 16; i++) begin
         if (i == 11) begin
            for (int s = 0; s < 5; s++) begin
               cycle(1'b1, 8'd11, 1'b0, 1'b0, mlen, b);
               check(ready_o == 1'b0, "ready_in_stall", 32'(ready_o), 0);
               check(valid_o == 1'b1, "valid_in_stall", 32'(valid_o), 1);
               check(data_o == stall_col, "data_in_stall", 32'(data_o), 32'(stall_col));
            end
         end
         send(W'(i));
      end
      drain();

      // Clear after 6 beats, with a sample offered in the clear cycle.
      for (int i = 0; i < 6; i++) send(W'(50 + i));
      cycle(1'b1, 8'd56, 1'b1, 1'b1, 4, b);
      for (int i = 0; i < 12; i++) send(W'(100 + i));
      drain();

      // Minimum line length, back-to-back.
      cycle(1'b0, '0, 1'b1, 1'b1, 2, b);
      for (int i = 0; i < 6; i++) send(W'(i));
      drain();

      // Reset in the middle of a primed line.
      cycle(1'b0, '0, 1'b1, 1'b1, 4, b);
      for (int i = 0; i < 10; i++) send(W'(20 + i));
      do_reset(4);
      for (int i = 0; i < 12; i++) send(W'(i));
      drain();

      // Random valid/ready; len_i wanders outside clear and must be ignored.
      cycle(1'b0, '0, 1'b1, 1'b1, int'($urandom_range(2, D)), b);
      beats = 0;
      cyc   = 0;
      while (beats < 1000 && cyc < 20000) begin
         cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0,
               int'($urandom_range(2, D)), b);
         if (b) beats++;
         cyc++;
      end
      check(beats == 1000, "random_beats", 32'(beats), 1000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
